// File: rtl/sm_pkg.sv
// Shared definitions for the state-machine command issuer: cs codes, opcodes,
// issuer FSM states and small decode helpers.
package sm_pkg;

  typedef enum logic [2:0] {
    CS_IDLE = 3'b000,
    CS_RUN  = 3'b001,
    CS_WAIT = 3'b010,
    CS_HALT = 3'b100
  } cs_e;

  typedef enum logic [1:0] {
    OP_START  = 2'b00,
    OP_RESUME = 2'b01,
    OP_STOP   = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT_ACK,
    ST_RESP
  } state_e;

  localparam int unsigned HOLD_W = 4;

  // cs code the controlled machine reports once a command has taken effect
  function automatic logic [2:0] expected_cs(input op_e op);
    logic [2:0] code;
    code = CS_RUN;
    if (op == OP_STOP) code = CS_HALT;
    return code;
  endfunction

  // one-hot strobe select, bit order {halt, cont, run}
  function automatic logic [2:0] strobe_sel(input op_e op);
    logic [2:0] sel;
    sel = '0;
    case (op)
      OP_START:  sel = 3'b001;
      OP_RESUME: sel = 3'b010;
      OP_STOP:   sel = 3'b100;
      default:   sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sm_pulse_stretch.sv
// Strobe hold: load a one-hot select, hold it for HOLD_CYCLES cycles as a
// registered level, flag the final held cycle on 'last'.
module sm_pulse_stretch
  import sm_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] sel,
  output logic [2:0] pulse,
  output logic       last
);

  localparam logic [HOLD_W-1:0] HOLD = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      pulse <= '0;
    end else if (load) begin
      cnt   <= HOLD;
      pulse <= sel;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == HOLD_W'(1)) pulse <= '0;
    end
  end

  assign last = (cnt == HOLD_W'(1));

endmodule

// File: rtl/sm_cmd_issuer.sv
// Issues run/cont/halt strobes to a controlled state machine and waits for the
// matching cs acknowledge. Define SM_CMD_TIMEOUT_EN to bound the acknowledge wait.
module sm_cmd_issuer
  import sm_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  input  logic [2:0] cs,
  output logic       run,
  output logic       cont,
  output logic       halt,
  output logic       busy,
  output logic       done,
  output logic       err
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES must be within 1..15");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be within 1..255");
  end

  state_e state;
  op_e    op_q;
  logic   match_seen;
  logic   accept;
  logic   load;
  logic   cs_hit;
  logic   hold_last;

`ifdef SM_CMD_TIMEOUT_EN
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
  logic [7:0] tcnt;
`endif

  assign accept = req_valid && req_ready;
  assign load   = accept && (op_e'(req_op) != OP_RSVD);
  assign cs_hit = (cs == expected_cs(op_q));

  sm_pulse_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_stretch (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .sel   (strobe_sel(op_e'(req_op))),
    .pulse ({halt, cont, run}),
    .last  (hold_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_START;
      match_seen <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef SM_CMD_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op_e'(req_op) == OP_RSVD) begin
              err <= 1'b1;
            end else begin
              op_q       <= op_e'(req_op);
              match_seen <= 1'b0;
              req_ready  <= 1'b0;
              busy       <= 1'b1;
              state      <= ST_DRIVE;
`ifdef SM_CMD_TIMEOUT_EN
              tcnt       <= '0;
`endif
            end
          end
        end
        ST_DRIVE: begin
          // an acknowledge arriving while the strobe is held is remembered
          if (cs_hit) match_seen <= 1'b1;
          if (hold_last) state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (cs_hit || match_seen) begin
            done  <= 1'b1;
            state <= ST_RESP;
          end
`ifdef SM_CMD_TIMEOUT_EN
          else if (tcnt == ACK_LAST) begin
            err   <= 1'b1;
            state <= ST_RESP;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_cmd_issuer.sv
// Self-checking bench for sm_cmd_issuer: directed scenarios plus random traffic
// against a timestamp-based reference model.
module tb_sm_cmd_issuer;

  localparam int H = 2;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;
  logic [2:0] cs;
  logic       run, cont, halt, busy, done, err;

  always #5 clk = ~clk;

  sm_cmd_issuer #(
    .HOLD_CYCLES(H),
    .ACK_TIMEOUT(T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .cs        (cs),
    .run       (run),
    .cont      (cont),
    .halt      (halt),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b ({0,ready,busy,done,err,halt,cont,run})",
               tag, act, exp);
    end
  endtask

  // Reference model: every command is described by the edge it was accepted on
  // (a_e) and the edge it resolved on (r_e); outputs follow from cycle arithmetic.
  bit         active, resolved, ok, seen;
  int         a_e, r_e, rsv_e, ec;
  logic [1:0] m_op;
  logic       exp_ready_prev;
  logic [2:0] cs_tab [4];

  function automatic logic [2:0] want_cs(input logic [1:0] op);
    return (op == 2'b10) ? 3'b100 : 3'b001;
  endfunction

  function automatic logic [7:0] expect_out(input int c);
    logic s, b, d, e;
    logic [2:0] stb;
    s   = active && (c >= a_e) && (c <= a_e + H - 1);
    stb = {s && (m_op == 2'b10), s && (m_op == 2'b01), s && (m_op == 2'b00)};
    b   = active && (!resolved || c <= r_e);
    d   = active && resolved && ok && (c == r_e);
    e   = (rsv_e == c) || (active && resolved && !ok && (c == r_e));
    return {1'b0, !b, b, d, e, stb};
  endfunction

  task automatic model_reset();
    active = 0; resolved = 0; ok = 0; seen = 0;
    a_e = 0; r_e = 0; rsv_e = -10; ec = 0; m_op = 2'b00;
    exp_ready_prev = 1'b1;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] op, input logic [2:0] c_s);
    int e;
    e = ec;
    if (active && resolved && e > r_e) active = 0;
    if (active && !resolved) begin
      if (e <= a_e + H) begin
        if (c_s == want_cs(m_op)) seen = 1;
      end else if (seen || c_s == want_cs(m_op)) begin
        resolved = 1; r_e = e; ok = 1;
      end
`ifdef SM_CMD_TIMEOUT_EN
      else if (e == a_e + H + T) begin
        resolved = 1; r_e = e; ok = 0;
      end
`endif
    end
    if (v && exp_ready_prev) begin
      if (op == 2'b11) rsv_e = e;
      else begin
        active = 1; resolved = 0; seen = 0; a_e = e; m_op = op;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [1:0] op, input logic [2:0] c_s);
    logic [7:0] e;
    req_valid = v; req_op = op; cs = c_s;
    @(posedge clk);
    ec++;
    model_edge(v, op, c_s);
    @(negedge clk);
    e = expect_out(ec);
    check_eq($sformatf("cycle%0d", ec),
             {1'b0, req_ready, busy, done, err, halt, cont, run}, e);
    exp_ready_prev = e[6];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cs_tab[0] = 3'b000; cs_tab[1] = 3'b001; cs_tab[2] = 3'b010; cs_tab[3] = 3'b100;
    model_reset();
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; cs = 3'b000;
    #100;
    check_eq("reset_state", {1'b0, req_ready, busy, done, err, halt, cont, run}, 8'b0100_0000);
    @(negedge clk);
    reset = 1'b1;

    // START accepted on the first edge after release, ack on 3rd cycle after accept
    cycle(1'b1, 2'b00, 3'b000);
    cycle(1'b0, 2'b00, 3'b000);
    cycle(1'b0, 2'b00, 3'b000);
    cycle(1'b0, 2'b00, 3'b001);
    repeat (3) cycle(1'b0, 2'b00, 3'b000);

    // STOP with cs already at halt code
    cycle(1'b1, 2'b10, 3'b100);
    repeat (5) cycle(1'b0, 2'b00, 3'b100);

    // reserved opcode, twice back to back
    cycle(1'b1, 2'b11, 3'b000);
    cycle(1'b1, 2'b11, 3'b000);
    repeat (2) cycle(1'b0, 2'b00, 3'b000);

    // RESUME with cs stuck at wait code: timeout or indefinite wait
    cycle(1'b1, 2'b01, 3'b010);
    repeat (25) cycle(1'b0, 2'b00, 3'b010);
    cycle(1'b0, 2'b00, 3'b001);
    repeat (3) cycle(1'b0, 2'b00, 3'b000);

    // back-to-back: valid held high, START then STOP
    cycle(1'b1, 2'b00, 3'b001);
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 2'b10, active ? want_cs(m_op) : 3'b000);
    repeat (4) cycle(1'b0, 2'b00, 3'b000);

    // reset abort while halt is being held
    cycle(1'b1, 2'b10, 3'b000);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("abort", {1'b0, req_ready, busy, done, err, halt, cont, run}, 8'b0100_0000);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (6) cycle(1'b0, 2'b00, 3'b100);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] op;
      r  = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      cycle($urandom_range(0, 3) != 0, op, cs_tab[$urandom_range(0, 3)]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
